z80_spi_master: RTL and testbench

Byte-wide SPI master for the SD card socket. It replaces the bit-banged GPIO port 0xF1 and input port 0xF0 path with a hardware shifter. It sits directly downstream of the top-level IO decoder, which supplies per-port read/write ticks, and drives sd_clk, sd_mosi and sd_ssel_n. The CPU starts an 8-bit mode-0 exchange with one OUT and polls status with IN, so per-bit software toggling is no longer needed.

---
 rtl/z80_spi_master_pkg.sv | 26 ++
 rtl/z80_spi_master_if.sv | 14 +
 rtl/z80_spi_master_half_timer.sv | 23 ++
 rtl/z80_spi_master.sv | 143 ++++++++++++++
 tb/tb_z80_spi_master.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/z80_spi_master_pkg.sv
// Shared encodings for the SD-card SPI master: register selects, ctrl/status
// bit positions, FSM state type and the divider default.
package z80_spi_pkg;

   localparam logic [1:0] SPI_DATA = 2'd0;
   localparam logic [1:0] SPI_CTRL = 2'd1;
   localparam logic [1:0] SPI_DIV  = 2'd2;
   localparam logic [1:0] SPI_RSVD = 2'd3;

   localparam int CTRL_SSEL    = 0;
   localparam int CTRL_AUTORD  = 1;
   localparam int CTRL_CLR_OVR = 7;

   localparam int STAT_BUSY = 7;
   localparam int STAT_DET  = 6;
   localparam int STAT_OVR  = 5;

   localparam int DIV_RESET_DEF = 22;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2
   } spi_state_t;

endpackage

// File: rtl/z80_spi_master_if.sv
// CPU-side IO bus for the SPI master: per-port ticks, write data and
// combinational read-back.
interface z80_spi_master_if;
   logic [1:0] port_sel;
   logic       wr_tick;
   logic       rd_tick;
   logic [7:0] din;
   logic [7:0] dout;

   modport master (output port_sel, output wr_tick, output rd_tick,
                   output din, input dout);
   modport slave  (input port_sel, input wr_tick, input rd_tick,
                   input din, output dout);
endinterface

// File: rtl/z80_spi_master_half_timer.sv
// Half-period down-counter: load on every FSM state entry, count to zero,
// expire while the count sits at zero.
module spi_half_timer #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             i_load,
   input  logic [DIV_W-1:0] i_load_val,
   output logic             o_expire
);

   logic [DIV_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (i_load)
         r_count <= i_load_val;
      else if (r_count != '0)
         r_count <= r_count - 1'b1;
   end

   assign o_expire = (r_count == '0);

endmodule

// File: rtl/z80_spi_master.sv
// Byte-wide mode-0 SPI master for the SD socket: one OUT starts an 8-bit
// exchange, IN polls status and returns the received byte.
module z80_spi_master
   import z80_spi_pkg::*;
#(
   parameter int DIV_W     = 8,
   parameter int DIV_RESET = DIV_RESET_DEF
) (
   input  logic              clk,
   input  logic              reset,
   z80_spi_master_if.slave   bus,
   input  logic              sd_miso,
   input  logic              sd_det,
   output logic              sd_clk,
   output logic              sd_mosi,
   output logic              sd_ssel_n,
   output logic              busy
);

   spi_state_t       r_state;
   logic [7:0]       r_tx;
   logic [7:0]       r_rx_shift;
   logic [7:0]       r_rx_data;
   logic [2:0]       r_bitcnt;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_div_act;
   logic             r_ssel;
   logic             r_autoread;
   logic             r_overrun;
   logic             r_sd_clk;
   logic             r_mosi;
   logic             r_busy;

   logic             w_idle;
   logic             w_wr;
   logic             w_rd;
   logic             w_data_wr;
   logic             w_auto_rd;
   logic             w_start_req;
   logic             w_start;
   logic             w_expire;
   logic             w_load;
   logic [DIV_W-1:0] w_load_val;
   logic [7:0]       w_tx_load;

   // A write in the same cycle as a read suppresses every read side effect.
   assign w_wr        = bus.wr_tick;
   assign w_rd        = bus.rd_tick & ~bus.wr_tick;
   assign w_idle      = (r_state == S_IDLE);
   assign w_data_wr   = w_wr & (bus.port_sel == SPI_DATA);
   assign w_auto_rd   = w_rd & (bus.port_sel == SPI_DATA) & r_autoread;
   assign w_start_req = w_data_wr | w_auto_rd;
   assign w_start     = w_start_req & w_idle;
   assign w_tx_load   = w_data_wr ? bus.din : 8'hFF;
   assign w_load      = w_start | (~w_idle & w_expire);
   assign w_load_val  = w_start ? r_div : r_div_act;

   spi_half_timer #(.DIV_W(DIV_W)) u_timer (
      .clk        (clk),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_expire   (w_expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_sd_clk   <= 1'b0;
         r_mosi     <= 1'b1;
         r_busy     <= 1'b0;
         r_ssel     <= 1'b0;
         r_autoread <= 1'b0;
         r_overrun  <= 1'b0;
         r_rx_data  <= 8'hFF;
         r_div      <= DIV_W'(DIV_RESET);
      end else begin
         if (w_wr && bus.port_sel == SPI_CTRL) begin
            r_ssel     <= bus.din[CTRL_SSEL];
            r_autoread <= bus.din[CTRL_AUTORD];
            if (bus.din[CTRL_CLR_OVR])
               r_overrun <= 1'b0;
         end
         if (w_wr && bus.port_sel == SPI_DIV && w_idle)
            r_div <= bus.din[DIV_W-1:0];
         if (w_start_req && !w_idle)
            r_overrun <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state   <= S_LOW;
                  r_tx      <= w_tx_load;
                  r_mosi    <= w_tx_load[7];
                  r_bitcnt  <= 3'd0;
                  r_div_act <= r_div;
                  r_busy    <= 1'b1;
               end
            end
            S_LOW: begin
               if (w_expire) begin
                  r_state    <= S_HIGH;
                  r_sd_clk   <= 1'b1;
                  r_rx_shift <= {r_rx_shift[6:0], sd_miso};
               end
            end
            S_HIGH: begin
               if (w_expire) begin
                  r_sd_clk <= 1'b0;
                  if (r_bitcnt == 3'd7) begin
                     r_state   <= S_IDLE;
                     r_rx_data <= r_rx_shift;
                     r_mosi    <= 1'b1;
                     r_busy    <= 1'b0;
                  end else begin
                     r_state  <= S_LOW;
                     r_tx     <= {r_tx[6:0], 1'b0};
                     r_mosi   <= r_tx[6];
                     r_bitcnt <= r_bitcnt + 3'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.dout = 8'hFF;
      case (bus.port_sel)
         SPI_DATA: bus.dout = r_rx_data;
         SPI_CTRL: bus.dout = {r_busy, sd_det, r_overrun, 2'b00, 1'b0,
                               r_autoread, r_ssel};
         SPI_DIV:  bus.dout = 8'(r_div);
         default:  bus.dout = 8'hFF;
      endcase
   end

   assign sd_clk    = r_sd_clk;
   assign sd_mosi   = r_mosi;
   assign sd_ssel_n = ~r_ssel;
   assign busy      = r_busy;

endmodule

// File: tb/tb_z80_spi_master.sv
// Directed bench for z80_spi_master: a MISO card model plus hand-computed
// expectations for reset, transfers, overrun, autoread, abort and divider.
module tb_z80_spi_master;
   import z80_spi_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic sd_miso, sd_det, sd_clk, sd_mosi, sd_ssel_n, busy;

   always #5 clk = ~clk;

   z80_spi_master_if bus ();

   z80_spi_master #(.DIV_W(8), .DIV_RESET(22)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .sd_miso   (sd_miso),
      .sd_det    (sd_det),
      .sd_clk    (sd_clk),
      .sd_mosi   (sd_mosi),
      .sd_ssel_n (sd_ssel_n),
      .busy      (busy)
   );

   // Card model: presents miso_byte MSB first, advancing after each sd_clk rise.
   int         rises = 0;
   int         rise_base;
   int         miso_idx;
   logic [7:0] miso_byte;
   logic [7:0] mosi_log = 8'h00;

   always @(posedge sd_clk) begin
      rises    <= rises + 1;
      mosi_log <= {mosi_log[6:0], sd_mosi};
   end

   assign miso_idx = rises - rise_base;
   assign sd_miso  = (miso_idx >= 0 && miso_idx < 8) ? miso_byte[3'(7 - miso_idx)] : 1'b1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] sel, input logic [7:0] d);
      bus.port_sel = sel;
      bus.din      = d;
      bus.wr_tick  = 1'b1;
      tick();
      bus.wr_tick  = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
      bus.port_sel = sel;
      #1;
      check(tag, bus.dout, exp);
   endtask

   task automatic prepare(input logic [7:0] b);
      miso_byte = b;
      rise_base = rises;
   endtask

   task automatic wait_done(output int cycles, output int first_rise);
      cycles     = 0;
      first_rise = -1;
      while (busy && cycles < 5000) begin
         cycles++;
         tick();
         if (sd_clk && first_rise < 0)
            first_rise = cycles;
      end
      if (busy)
         check("busy_timeout", busy, 0);
   endtask

   int cyc, first;

   initial begin
      reset        = 1'b1;
      bus.port_sel = SPI_DATA;
      bus.din      = 8'h00;
      bus.wr_tick  = 1'b0;
      bus.rd_tick  = 1'b0;
      sd_det       = 1'b1;
      miso_byte    = 8'hFF;
      rise_base    = 0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      check("rst_ssel_n", sd_ssel_n, 1);
      check("rst_mosi", sd_mosi, 1);
      check("rst_sdclk", sd_clk, 0);
      check("rst_busy", busy, 0);
      check_reg("rst_status", SPI_CTRL, 8'h40);
      check_reg("rst_div", SPI_DIV, 8'd22);
      check_reg("rst_data", SPI_DATA, 8'hFF);
      check_reg("rsvd_read", SPI_RSVD, 8'hFF);
      sd_det = 1'b0;
      check_reg("status_nodet", SPI_CTRL, 8'h00);
      sd_det = 1'b1;

      // Basic exchange at div=1
      wr(SPI_DIV, 8'd1);
      check_reg("div_wr1", SPI_DIV, 8'd1);
      prepare(8'h3C);
      wr(SPI_DATA, 8'hA5);
      check("a5_start_busy", busy, 1);
      check("a5_start_mosi", sd_mosi, 1);
      check("a5_start_sdclk", sd_clk, 0);
      wait_done(cyc, first);
      check("a5_busy_cycles", cyc, 32);
      check("a5_first_rise", first, 2);
      check("a5_mosi_bits", mosi_log, 8'hA5);
      check("a5_rise_count", rises - rise_base, 8);
      check_reg("a5_rx", SPI_DATA, 8'h3C);
      check_reg("a5_status", SPI_CTRL, 8'h40);

      // Write while busy: ignored, flags overrun
      prepare(8'h5A);
      wr(SPI_DATA, 8'h96);
      repeat (3) tick();
      wr(SPI_DATA, 8'h00);
      check_reg("ovr_status_busy", SPI_CTRL, 8'hE0);
      wait_done(cyc, first);
      check("ovr_mosi_bits", mosi_log, 8'h96);
      check_reg("ovr_rx", SPI_DATA, 8'h5A);
      check_reg("ovr_status", SPI_CTRL, 8'h60);
      wr(SPI_CTRL, 8'h80);
      check_reg("ovr_cleared", SPI_CTRL, 8'h40);

      // Autoread at div=0
      wr(SPI_DIV, 8'd0);
      wr(SPI_CTRL, 8'h03);
      check("ssel_on", sd_ssel_n, 0);
      check_reg("auto_status", SPI_CTRL, 8'h43);
      prepare(8'hC3);
      bus.port_sel = SPI_DATA;
      bus.rd_tick  = 1'b1;
      #1;
      check("auto_prev_rx", bus.dout, 8'h5A);
      tick();
      bus.rd_tick = 1'b0;
      check("auto_busy", busy, 1);
      check_reg("auto_rx_hold", SPI_DATA, 8'h5A);
      wait_done(cyc, first);
      check("auto_cycles", cyc, 16);
      check("auto_mosi_bits", mosi_log, 8'hFF);
      check_reg("auto_rx_new", SPI_DATA, 8'hC3);

      // Read and write together: the written byte is sent
      prepare(8'h00);
      bus.port_sel = SPI_DATA;
      bus.din      = 8'h81;
      bus.wr_tick  = 1'b1;
      bus.rd_tick  = 1'b1;
      tick();
      bus.wr_tick  = 1'b0;
      bus.rd_tick  = 1'b0;
      check("rdwr_mosi", sd_mosi, 1);
      wait_done(cyc, first);
      check("rdwr_cycles", cyc, 16);
      check("rdwr_mosi_bits", mosi_log, 8'h81);
      check_reg("rdwr_rx", SPI_DATA, 8'h00);

      // Reset mid-transfer
      wr(SPI_DIV, 8'd1);
      prepare(8'h0F);
      wr(SPI_DATA, 8'h00);
      check("abort_mosi_bit7", sd_mosi, 0);
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_sdclk", sd_clk, 0);
      check("abort_mosi", sd_mosi, 1);
      check("abort_busy", busy, 0);
      check("abort_ssel_n", sd_ssel_n, 1);
      check_reg("abort_rx", SPI_DATA, 8'hFF);
      check_reg("abort_status", SPI_CTRL, 8'h40);
      check_reg("abort_div", SPI_DIV, 8'd22);

      // Divider write while busy is ignored
      prepare(8'hAA);
      wr(SPI_DATA, 8'h55);
      wr(SPI_DIV, 8'd4);
      check_reg("div_busy_ignored", SPI_DIV, 8'd22);
      wait_done(cyc, first);
      check("div22_cycles", cyc, 367);
      check("div22_mosi_bits", mosi_log, 8'h55);
      check_reg("div22_rx", SPI_DATA, 8'hAA);
      wr(SPI_DIV, 8'd4);
      check_reg("div_idle_wr", SPI_DIV, 8'd4);
      wr(SPI_RSVD, 8'h00);
      check_reg("rsvd_wr_ignored", SPI_DIV, 8'd4);
      prepare(8'h33);
      wr(SPI_DATA, 8'hCC);
      wait_done(cyc, first);
      check("div4_cycles", cyc, 80);
      check("div4_first_rise", first, 5);
      check("div4_mosi_bits", mosi_log, 8'hCC);
      check_reg("div4_rx", SPI_DATA, 8'h33);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
